spi_byte_master: RTL and testbench
==================================

// Module: spi_byte_master
// PURPOSE
//  Mode-0 (CPOL=0, CPHA=0) SPI byte engine. One start pulse shifts one byte out MSB-first on
//  spi_mosi and captures one byte from spi_miso. Sits directly downstream of the SD-card init
//  and command sequencers, which drive start/data and wait on rdy. Owns SCLK generation and a
//  slow/fast rate select: slow for card init (<=400 kHz), fast for data transfer.
// PARAMETERS
//  DIV_SLOW  62  clk cycles per SCLK half-period when fast_mode=0 (>=1)
//  DIV_FAST  2   clk cycles per SCLK half-period when fast_mode=1 (>=1)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  start      in   1  1-cycle request; accepted only when busy=0
//  data       in   8  TX byte, sampled in the cycle start is accepted
//  fast_mode  in   1  rate select, sampled in the cycle start is accepted
//  rdy        out  1  1-cycle pulse: byte complete, rx_data valid
//  busy       out  1  high while a byte is in flight
//  rx_data    out  8  last received byte; held until the next completion
//  spi_sclk   out  1  SPI clock, idles low
//  spi_mosi   out  1  SPI data out, idles high
//  spi_miso   in   1  SPI data in
// BEHAVIOUR
//  - All outputs registered. Reset values: spi_sclk=0, spi_mosi=1, rdy=0, busy=0, rx_data=0.
//  - States: IDLE, LOW (sclk=0), HIGH (sclk=1).
//  - IDLE + start: latch data into tx_sr; latch div = fast_mode ? DIV_FAST : DIV_SLOW;
//    bit_cnt=0; half_cnt=0. Next cycle: state=LOW, busy=1, spi_mosi=data[7].
//  - half_cnt counts 0..div-1 in LOW and HIGH. Phase ends when half_cnt==div-1.
//  - End of LOW: sclk rises, spi_miso shifts into rx_sr LSB, state=HIGH.
//  - End of HIGH: sclk falls.
//    - If bit_cnt<7: bit_cnt++, spi_mosi=next tx bit, state=LOW.
//    - If bit_cnt==7: state=IDLE, busy=0, rdy=1 for one cycle, rx_data=rx_sr including the
//      last sample, spi_mosi=1.
//  - Latency: rdy is high exactly 16*div+1 cycles after the accepting cycle (DIV_FAST=2 -> 33).
//  - Back-to-back: start is accepted in the same cycle rdy is high (busy=0 there). The next byte
//    then begins with no extra idle cycle.
//  - start while busy=1: ignored, no queuing. data/fast_mode changes mid-byte: no effect.
//  - rst mid-byte: abort immediately. Outputs take reset values on the next edge; no rdy pulse.
//  - Chip select is not driven here; CS ownership stays with the sequencers.
// STRUCTURE
//  - Shared package: state encodings (IDLE/LOW/HIGH), SPI_MOSI_IDLE=1'b1, SD_INIT_FILL=8'hFF,
//    default DIV_SLOW/DIV_FAST values.
//  - One sub-module: spi_half_clk_div.
//    - Loadable half-period counter; width = clog2(max(DIV_SLOW,DIV_FAST)).
//    - Outputs a 'phase_end' tick; cleared on start and rst.
//  - Top: FSM, tx/rx shift registers, bit counter.
// TESTING
//  1. fast_mode=1, DIV_FAST=2, data=8'hA5, MISO loopback from MOSI -> MOSI bits 1,0,1,0,0,1,0,1
//     each stable across the rising edge; rx_data=8'hA5; rdy high exactly 33 cycles after start.
//  2. fast_mode=0, DIV_SLOW=62, data=8'hFF, MISO tied 0 -> 8 SCLK pulses, each high for 62 clk;
//     rx_data=8'h00; rdy at cycle 993.
//  3. 256 x 8'hFF, start issued on each rdy cycle -> no gap between bytes, 256 rdy pulses,
//     MOSI constantly 1, busy never drops between bytes except in rdy cycles.
//  4. start pulsed during bit 3 of a byte -> ignored; exactly one rdy; rx_data from first byte.
//  5. rst asserted at bit 5 -> next cycle sclk=0, mosi=1, busy=0, no rdy; a fresh start then
//     completes normally with correct rx_data.
//  6. fast_mode toggled mid-byte -> SCLK period unchanged until rdy; the next byte uses the
//     new rate.

Source files
------------

// File: rtl/spi_byte_master_pkg.sv
// Shared definitions for the SPI byte engine: FSM encoding, idle levels, default rates.
package spi_byte_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } spi_state_t;

   localparam logic        SPI_MOSI_IDLE    = 1'b1;
   localparam logic [7:0]  SD_INIT_FILL     = 8'hFF;
   localparam int unsigned DIV_SLOW_DEFAULT = 62;
   localparam int unsigned DIV_FAST_DEFAULT = 2;
   localparam int unsigned BYTE_BITS        = 8;

   function automatic int unsigned max_div(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_half_clk_div.sv
// Loadable SCLK half-period counter; phase_end is high during the last clk of each half-period.
module spi_half_clk_div #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   input  logic [CNT_W-1:0] last,
   output logic             phase_end
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last_q;

   // phase_end is computed one cycle ahead so it lines up with cnt == last_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         last_q    <= '0;
         phase_end <= 1'b0;
      end else if (load) begin
         cnt       <= '0;
         last_q    <= last;
         phase_end <= (last == '0);
      end else if (enable) begin
         if (phase_end) begin
            cnt       <= '0;
            phase_end <= (last_q == '0);
         end else begin
            cnt       <= cnt + CNT_W'(1);
            phase_end <= ((cnt + CNT_W'(1)) == last_q);
         end
      end else begin
         cnt       <= '0;
         phase_end <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0 SPI byte engine: shifts one byte out MSB-first and captures one byte per start.
module spi_byte_master
   import spi_byte_master_pkg::*;
#(
   parameter int unsigned DIV_SLOW = DIV_SLOW_DEFAULT,
   parameter int unsigned DIV_FAST = DIV_FAST_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   input  logic       fast_mode,
   output logic       rdy,
   output logic       busy,
   output logic [7:0] rx_data,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso
);

   localparam int unsigned DIV_MAX = max_div(DIV_SLOW, DIV_FAST);
   localparam int unsigned CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

   spi_state_t       state;
   logic [7:0]       tx_sr;
   logic [7:0]       rx_sr;
   logic [2:0]       bit_cnt;
   logic             accept;
   logic             active;
   logic             phase_end;
   logic [CNT_W-1:0] div_last;

   assign accept   = (state == ST_IDLE) && start;
   assign active   = (state != ST_IDLE);
   assign div_last = fast_mode ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_SLOW - 1);

   spi_half_clk_div #(
      .CNT_W (CNT_W)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .enable    (active),
      .last      (div_last),
      .phase_end (phase_end)
   );

   // Byte FSM: LOW ends by raising SCLK and sampling MISO, HIGH ends by lowering SCLK.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         tx_sr    <= '0;
         rx_sr    <= '0;
         bit_cnt  <= '0;
         rdy      <= 1'b0;
         busy     <= 1'b0;
         rx_data  <= '0;
         spi_sclk <= 1'b0;
         spi_mosi <= SPI_MOSI_IDLE;
      end else begin
         rdy <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  tx_sr    <= data;
                  bit_cnt  <= '0;
                  busy     <= 1'b1;
                  spi_sclk <= 1'b0;
                  spi_mosi <= data[7];
                  state    <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (phase_end) begin
                  spi_sclk <= 1'b1;
                  rx_sr    <= {rx_sr[6:0], spi_miso};
                  state    <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (phase_end) begin
                  spi_sclk <= 1'b0;
                  if (bit_cnt != 3'(BYTE_BITS - 1)) begin
                     bit_cnt  <= bit_cnt + 3'd1;
                     spi_mosi <= tx_sr[6];
                     tx_sr    <= {tx_sr[6:0], SPI_MOSI_IDLE};
                     state    <= ST_LOW;
                  end else begin
                     busy     <= 1'b0;
                     rdy      <= 1'b1;
                     rx_data  <= rx_sr;
                     spi_mosi <= SPI_MOSI_IDLE;
                     state    <= ST_IDLE;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               spi_sclk <= 1'b0;
               spi_mosi <= SPI_MOSI_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: vector table, random bytes, back-to-back stream, abort by reset.
module tb_spi_byte_master;

   localparam int DIV_S = 62;
   localparam int DIV_F = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] data;
   logic       fast_mode;
   logic       rdy;
   logic       busy;
   logic [7:0] rx_data;
   logic       spi_sclk;
   logic       spi_mosi;
   logic       spi_miso;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] d;
      logic       fast;
      logic [7:0] mb;      // byte presented on MISO when not looped back
      logic       loop;    // MISO follows MOSI
      int         glitch;  // 0 none, 1 start pulse mid-byte, 2 fast_mode flip mid-byte
      logic [7:0] exp_rx;
      int         exp_lat;
   } vec_t;

   vec_t vecs[$];

   spi_byte_master #(
      .DIV_SLOW (DIV_S),
      .DIV_FAST (DIV_F)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data      (data),
      .fast_mode (fast_mode),
      .rdy       (rdy),
      .busy      (busy),
      .rx_data   (rx_data),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] d, input logic fast, input logic [7:0] mb,
                               input logic loop, input int glitch);
      vec_t v;
      v.d       = d;
      v.fast    = fast;
      v.mb      = mb;
      v.loop    = loop;
      v.glitch  = glitch;
      v.exp_rx  = loop ? d : mb;
      v.exp_lat = 16 * (fast ? DIV_F : DIV_S) + 1;
      return v;
   endfunction

   // One byte transaction observed against the SPI rules; cycles are counted from the accept cycle.
   task automatic do_byte(input vec_t v, input string tag);
      int   div      = v.fast ? DIV_F : DIV_S;
      int   n        = 0;
      int   rises    = 0;
      int   hi       = 0;
      int   extra    = 0;
      logic prev;
      bit   hi_bad   = 0;
      bit   mosi_bad = 0;
      logic [7:0] dv;
      dv = v.d;
      @(negedge clk);
      start     = 1'b1;
      data      = v.d;
      fast_mode = v.fast;
      spi_miso  = v.loop ? spi_mosi : v.mb[7];
      prev      = spi_sclk;
      while (rdy !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (spi_sclk && !prev) begin
            if (rises < 8 && spi_mosi !== dv[3'(7 - rises)]) mosi_bad = 1;
            rises++;
            hi = 1;
            if (rises == 4 && v.glitch == 1) begin
               start = 1'b1;
               data  = 8'h00;
            end
            if (rises == 4 && v.glitch == 2) fast_mode = ~v.fast;
         end else if (spi_sclk) begin
            hi++;
         end else if (prev) begin
            if (hi != div) hi_bad = 1;
         end
         prev = spi_sclk;
         if (v.loop) spi_miso = spi_mosi;
         else        spi_miso = (rises < 8) ? v.mb[3'(7 - rises)] : 1'b0;
      end
      chk({tag, " latency"}, 32'(n), 32'(v.exp_lat));
      chk({tag, " rx_data"}, 32'(rx_data), 32'(v.exp_rx));
      chk({tag, " sclk pulses"}, 32'(rises), 32'd8);
      chk({tag, " sclk high width"}, 32'(hi_bad), 32'd0);
      chk({tag, " mosi bits"}, 32'(mosi_bad), 32'd0);
      chk({tag, " busy in rdy cycle"}, 32'(busy), 32'd0);
      repeat (4 * div + 4) begin
         @(negedge clk);
         if (rdy !== 1'b0) extra++;
      end
      chk({tag, " extra rdy"}, 32'(extra), 32'd0);
      chk({tag, " idle mosi"}, 32'(spi_mosi), 32'd1);
   endtask

   initial begin
      int rdys, n, last, gap_bad, busy_bad, mosi_bad, rises, idle_rdy;
      logic prev;

      rst = 1'b1; start = 1'b0; data = 8'h00; fast_mode = 1'b0; spi_miso = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset sclk", 32'(spi_sclk), 32'd0);
      chk("reset mosi", 32'(spi_mosi), 32'd1);
      chk("reset rdy", 32'(rdy), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset rx_data", 32'(rx_data), 32'd0);
      rst = 1'b0;

      vecs.push_back(mk(8'hA5, 1'b1, 8'h00, 1'b1, 0));
      vecs.push_back(mk(8'hFF, 1'b0, 8'h00, 1'b0, 0));
      vecs.push_back(mk(8'h3C, 1'b1, 8'hC3, 1'b0, 1));
      vecs.push_back(mk(8'h5A, 1'b1, 8'h96, 1'b0, 2));
      vecs.push_back(mk(8'h81, 1'b0, 8'h7E, 1'b0, 2));
      vecs.push_back(mk(8'h00, 1'b1, 8'hFF, 1'b0, 0));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk(8'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom),
                           1'($urandom_range(0, 1)), 0));

      foreach (vecs[i]) do_byte(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back stream of fill bytes, restarted in every rdy cycle.
      rdys = 0; n = 0; last = 0; gap_bad = 0; busy_bad = 0; mosi_bad = 0;
      @(negedge clk);
      start = 1'b1; data = 8'hFF; fast_mode = 1'b1; spi_miso = 1'b1;
      while (rdys < 256 && n < 20000) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (rdy === 1'b1) begin
            rdys++;
            if (n - last != 16 * DIV_F + 1) gap_bad++;
            last = n;
            if (busy !== 1'b0) busy_bad++;
            if (rdys < 256) start = 1'b1;
         end else if (busy !== 1'b1) begin
            busy_bad++;
         end
         if (spi_mosi !== 1'b1) mosi_bad++;
      end
      chk("b2b rdy count", 32'(rdys), 32'd256);
      chk("b2b gaps", 32'(gap_bad), 32'd0);
      chk("b2b busy", 32'(busy_bad), 32'd0);
      chk("b2b mosi", 32'(mosi_bad), 32'd0);
      chk("b2b rx_data", 32'(rx_data), 32'hFF);

      // Abort with reset during bit 5, then a clean transfer.
      repeat (5) @(negedge clk);
      start = 1'b1; data = 8'hC6; fast_mode = 1'b1; spi_miso = 1'b0;
      rises = 0; n = 0; prev = spi_sclk;
      while (rises < 6 && n < 500) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (spi_sclk && !prev) rises++;
         prev = spi_sclk;
      end
      chk("abort reached bit 5", 32'(rises), 32'd6);
      rst = 1'b1;
      @(negedge clk);
      chk("abort sclk", 32'(spi_sclk), 32'd0);
      chk("abort mosi", 32'(spi_mosi), 32'd1);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort rdy", 32'(rdy), 32'd0);
      chk("abort rx_data", 32'(rx_data), 32'd0);
      rst = 1'b0;
      idle_rdy = 0;
      repeat (40) begin
         @(negedge clk);
         if (rdy !== 1'b0 || busy !== 1'b0) idle_rdy++;
      end
      chk("abort no rdy", 32'(idle_rdy), 32'd0);
      do_byte(mk(8'hC6, 1'b1, 8'h00, 1'b1, 0), "after abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
